cmp_unit_pipe: RTL and testbench
================================

# cmp_unit_pipe

Parametrised, two-stage pipelined compare unit for the ALU. It is the successor of the single-cycle compare unit. It adds the following over that unit:
- signed/unsigned comparison
- a three-bit function code with a corrected less-than function
- MIN/MAX selection
- a running min/max tracker and a saturating match counter

It sits beside the arithmetic, logic and shift units behind the ALU function decoder and shares their flag/output muxing.

## Interface
Parameters:
- DATA_WIDTH, 8, operand and result width (≥2)
- CNT_WIDTH, 8, match-counter width (≥1)

Ports:
- clk  in  1  rising-edge clock
- RST  in  1  asynchronous, active-high reset
- A_Cmp  in  DATA_WIDTH  operand A
- B_Cmp  in  DATA_WIDTH  operand B
- CMP_EN  in  1  issue strobe; one operation per asserted cycle
- ALU_FUN  in  3  function code, sampled with CMP_EN
- SIGNED_MODE  in  1  1 = two's-complement compare, sampled with CMP_EN
- CLR_TRACK  in  1  clears tracker and counter
- CMP_OUT_reg  out  DATA_WIDTH  registered result
- CMP_Flag_reg  out  1  result-valid, one cycle per issued operation
- TRK_MIN  out  DATA_WIDTH  running minimum
- TRK_MAX  out  DATA_WIDTH  running maximum
- TRK_VLD  out  1  tracker holds at least one sample
- MATCH_CNT  out  CNT_WIDTH  saturating count of A==B events under CNT

## Operation
- **Stage 1:** on CMP_EN=1 it registers A, B, ALU_FUN, SIGNED_MODE and sets the internal valid s1_vld. When CMP_EN=0, s1_vld=0 and the operand registers hold.
- **Stage 2:** computes from the stage-1 registers. CMP_OUT_reg and CMP_Flag_reg load s1_vld's result. When s1_vld=0, CMP_Flag_reg=0 and CMP_OUT_reg is forced to 0.
- **Function codes** (all comparisons follow SIGNED_MODE):
  - 000 NOP: out 0
  - 001 EQ: out 1 if A==B, else 0
  - 010 GT: out 2 if A>B, else 0
  - 011 LT: out 3 if A<B, else 0
  - 100 MAX: out max(A,B)
  - 101 MIN: out min(A,B)
  - 110 TRACK: out A.
    - If TRK_VLD=0: TRK_MIN=TRK_MAX=A and TRK_VLD←1.
    - Otherwise: TRK_MIN←min(TRK_MIN,A) and TRK_MAX←max(TRK_MAX,A).
  - 111 CNT: if A==B, MATCH_CNT increments, saturating at 2^CNT_WIDTH−1. Out is the post-update MATCH_CNT, zero-extended or truncated to DATA_WIDTH.
- **Tracker signedness:** the tracker compares using the SIGNED_MODE of the current TRACK op. Mixing modes between clears is legal but its result is undefined; verification does not check it.
- **Result widths:** EQ/GT/LT codes are zero-extended to DATA_WIDTH.
- **CLR_TRACK** takes effect at the clock edge where it is high: TRK_VLD=0, TRK_MIN=TRK_MAX=0, MATCH_CNT=0.
- **Clear coincident with a completing TRACK/CNT op:** the clear is applied first, then the op.
  - TRACK: TRK_VLD=1, TRK_MIN=TRK_MAX=A.
  - CNT: MATCH_CNT=1 if A==B, else 0.
- CLR_TRACK does not affect pipeline contents or CMP_OUT_reg/CMP_Flag_reg.

## Timing
- **Reset:** RST asserted clears all outputs and internal state immediately, without waiting for clk.
  - CMP_OUT_reg=0, CMP_Flag_reg=0, TRK_MIN=0, TRK_MAX=0, TRK_VLD=0, MATCH_CNT=0, s1_vld=0.
- **Latency:** an op issued with CMP_EN high at edge N has its result on CMP_OUT_reg/CMP_Flag_reg after edge N+1. Tracker and counter also update at edge N+1.
- **Throughput:** one op per cycle, no stalls. Back-to-back TRACK/CNT ops each see the state left by the previous op.
- **Reset mid-operation:** in-flight ops are discarded. No CMP_Flag_reg pulse appears after RST deasserts unless new ops are issued.
- **Counter saturation:** holds at all-ones and never wraps.

## Configuration
- **CMP_TRACK_EN defined:** TRACK and CNT behave as above.
- **CMP_TRACK_EN undefined:**
  - The tracker and counter logic is not built.
  - Codes 110/111 behave as NOP (out 0, CMP_Flag_reg still pulses).
  - TRK_MIN, TRK_MAX, TRK_VLD and MATCH_CNT are tied to 0.
  - The ports remain present.

## Test plan
- **Reset:** hold RST with random inputs toggling.
  - All outputs are 0.
  - After release, issue EQ A=5,B=5 → CMP_OUT_reg=1 and CMP_Flag_reg=1 exactly 2 edges after issue.
- **Signed vs unsigned** (DATA_WIDTH=8), A=8'hF0, B=8'h10:
  - GT unsigned → 2; GT signed → 0
  - LT signed → 3
  - MAX signed → 8'h10; MIN unsigned → 8'h10
- **Back-to-back issue:** ops EQ, GT, LT, MAX on consecutive cycles → four consecutive CMP_Flag_reg pulses with matching results in order.
  - A CMP_EN=0 gap produces a 0 flag cycle and CMP_OUT_reg=0.
- **Tracker:** unsigned TRACK with A=7, 3, 9 → TRK_MIN=3, TRK_MAX=9, TRK_VLD=1.
  - CLR_TRACK coincident with completion of TRACK A=4 → TRK_MIN=TRK_MAX=4, TRK_VLD=1.
- **Counter saturation:** with CNT_WIDTH=2, issue CNT with A==B five times → MATCH_CNT sequence 1, 2, 3, 3, 3.
  - A CNT with A≠B leaves the count unchanged.
  - CLR_TRACK → 0.
- **Configuration:** build without CMP_TRACK_EN.
  - TRACK with A=9 → CMP_OUT_reg=0, CMP_Flag_reg=1.
  - TRK_MIN, TRK_MAX, TRK_VLD and MATCH_CNT stay 0.

Source files
------------

// File: rtl/cmp_unit_pipe_if.sv
// Bundle of operand, control and result signals for cmp_unit_pipe.
// The master side (function decoder or bench) drives operands and controls;
// the slave side (the compare unit) drives results and tracker state.
//   A_Cmp/B_Cmp    operands              CMP_EN      issue strobe
//   ALU_FUN        function code         SIGNED_MODE two's-complement select
//   CLR_TRACK      tracker/counter clear
//   CMP_OUT_reg    registered result     CMP_Flag_reg result valid
//   TRK_MIN/MAX    running min/max       TRK_VLD     tracker holds a sample
//   MATCH_CNT      saturating match count
interface cmp_unit_pipe_if #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 8
);
  logic [DATA_WIDTH-1:0] A_Cmp;
  logic [DATA_WIDTH-1:0] B_Cmp;
  logic                  CMP_EN;
  logic [2:0]            ALU_FUN;
  logic                  SIGNED_MODE;
  logic                  CLR_TRACK;
  logic [DATA_WIDTH-1:0] CMP_OUT_reg;
  logic                  CMP_Flag_reg;
  logic [DATA_WIDTH-1:0] TRK_MIN;
  logic [DATA_WIDTH-1:0] TRK_MAX;
  logic                  TRK_VLD;
  logic [CNT_WIDTH-1:0]  MATCH_CNT;

  modport master (
    output A_Cmp, B_Cmp, CMP_EN, ALU_FUN, SIGNED_MODE, CLR_TRACK,
    input  CMP_OUT_reg, CMP_Flag_reg, TRK_MIN, TRK_MAX, TRK_VLD, MATCH_CNT
  );

  modport slave (
    input  A_Cmp, B_Cmp, CMP_EN, ALU_FUN, SIGNED_MODE, CLR_TRACK,
    output CMP_OUT_reg, CMP_Flag_reg, TRK_MIN, TRK_MAX, TRK_VLD, MATCH_CNT
  );
endinterface

// File: rtl/cmp_unit_pipe.sv
// Two-stage pipelined compare unit: EQ/GT/LT codes, MAX/MIN select, and
// (when the CMP_TRACK_EN macro is defined) a running min/max tracker plus a
// saturating A==B match counter. Without CMP_TRACK_EN, codes 110/111 act as
// NOP and the tracker outputs are tied to zero.
// Ports:
//   clk  rising-edge clock
//   RST  asynchronous active-high reset
//   bus  cmp_unit_pipe_if slave: operands/controls in, result/tracker out
// Stage 1 registers the issued op; stage 2 registers the result one edge
// later, together with the tracker/counter update.
module cmp_unit_pipe #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 8
) (
  input  logic              clk,
  input  logic              RST,
  cmp_unit_pipe_if.slave    bus
);

  localparam logic [2:0] FUN_NOP   = 3'b000;
  localparam logic [2:0] FUN_EQ    = 3'b001;
  localparam logic [2:0] FUN_GT    = 3'b010;
  localparam logic [2:0] FUN_LT    = 3'b011;
  localparam logic [2:0] FUN_MAX   = 3'b100;
  localparam logic [2:0] FUN_MIN   = 3'b101;
  localparam logic [2:0] FUN_TRACK = 3'b110;
  localparam logic [2:0] FUN_CNT   = 3'b111;

  logic [DATA_WIDTH-1:0] s1_a;
  logic [DATA_WIDTH-1:0] s1_b;
  logic [2:0]            s1_fun;
  logic                  s1_sgn;
  logic                  s1_vld;

  logic [DATA_WIDTH-1:0] out_q;
  logic                  flag_q;
  logic [DATA_WIDTH-1:0] result;
  logic                  a_eq_b;
  logic                  a_lt_b;
  logic                  a_gt_b;

  function automatic logic lt_f(input logic [DATA_WIDTH-1:0] x,
                                input logic [DATA_WIDTH-1:0] y,
                                input logic                  sgn);
    if (sgn) return $signed(x) < $signed(y);
    return x < y;
  endfunction

  // Operand registers hold when idle; only the valid bit drops.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      s1_a   <= '0;
      s1_b   <= '0;
      s1_fun <= FUN_NOP;
      s1_sgn <= 1'b0;
      s1_vld <= 1'b0;
    end else begin
      s1_vld <= bus.CMP_EN;
      if (bus.CMP_EN) begin
        s1_a   <= bus.A_Cmp;
        s1_b   <= bus.B_Cmp;
        s1_fun <= bus.ALU_FUN;
        s1_sgn <= bus.SIGNED_MODE;
      end
    end
  end

  always_comb begin
    a_eq_b = (s1_a == s1_b);
    a_lt_b = lt_f(s1_a, s1_b, s1_sgn);
    a_gt_b = lt_f(s1_b, s1_a, s1_sgn);
  end

`ifdef CMP_TRACK_EN
  logic [DATA_WIDTH-1:0] trk_min_q, trk_min_d;
  logic [DATA_WIDTH-1:0] trk_max_q, trk_max_d;
  logic                  trk_vld_q, trk_vld_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] cnt_ext;

  // Clear is folded in first so a coincident TRACK/CNT op lands on a
  // freshly cleared tracker.
  always_comb begin
    trk_min_d = bus.CLR_TRACK ? '0 : trk_min_q;
    trk_max_d = bus.CLR_TRACK ? '0 : trk_max_q;
    trk_vld_d = bus.CLR_TRACK ? 1'b0 : trk_vld_q;
    cnt_d     = bus.CLR_TRACK ? '0 : cnt_q;
    if (s1_vld && (s1_fun == FUN_TRACK)) begin
      if (!trk_vld_d) begin
        trk_min_d = s1_a;
        trk_max_d = s1_a;
        trk_vld_d = 1'b1;
      end else begin
        if (lt_f(s1_a, trk_min_d, s1_sgn)) trk_min_d = s1_a;
        if (lt_f(trk_max_d, s1_a, s1_sgn)) trk_max_d = s1_a;
      end
    end
    if (s1_vld && (s1_fun == FUN_CNT) && a_eq_b && (cnt_d != {CNT_WIDTH{1'b1}}))
      cnt_d = cnt_d + CNT_WIDTH'(1);
  end

  if (CNT_WIDTH >= DATA_WIDTH) begin : g_cnt_trunc
    assign cnt_ext = cnt_d[DATA_WIDTH-1:0];
  end else begin : g_cnt_zext
    assign cnt_ext = {{(DATA_WIDTH-CNT_WIDTH){1'b0}}, cnt_d};
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      trk_min_q <= '0;
      trk_max_q <= '0;
      trk_vld_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      trk_min_q <= trk_min_d;
      trk_max_q <= trk_max_d;
      trk_vld_q <= trk_vld_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bus.TRK_MIN   = trk_min_q;
  assign bus.TRK_MAX   = trk_max_q;
  assign bus.TRK_VLD   = trk_vld_q;
  assign bus.MATCH_CNT = cnt_q;
`else
  logic unused_clr;
  assign unused_clr    = bus.CLR_TRACK;
  assign bus.TRK_MIN   = '0;
  assign bus.TRK_MAX   = '0;
  assign bus.TRK_VLD   = 1'b0;
  assign bus.MATCH_CNT = '0;
`endif

  always_comb begin
    result = '0;
    case (s1_fun)
      FUN_NOP:   result = '0;
      FUN_EQ:    result = a_eq_b ? DATA_WIDTH'(1) : '0;
      FUN_GT:    result = a_gt_b ? DATA_WIDTH'(2) : '0;
      FUN_LT:    result = a_lt_b ? DATA_WIDTH'(3) : '0;
      FUN_MAX:   result = a_gt_b ? s1_a : s1_b;
      FUN_MIN:   result = a_lt_b ? s1_a : s1_b;
`ifdef CMP_TRACK_EN
      FUN_TRACK: result = s1_a;
      FUN_CNT:   result = cnt_ext;
`else
      FUN_TRACK, FUN_CNT: result = '0;
`endif
    endcase
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      out_q  <= '0;
      flag_q <= 1'b0;
    end else begin
      out_q  <= s1_vld ? result : '0;
      flag_q <= s1_vld;
    end
  end

  assign bus.CMP_OUT_reg  = out_q;
  assign bus.CMP_Flag_reg = flag_q;

endmodule

// File: tb/tb_cmp_unit_pipe.sv
module tb_cmp_unit_pipe;
  localparam int DW = 8;
  localparam int CW = 2;

  localparam logic [2:0] NOP = 3'b000, EQ = 3'b001, GT = 3'b010, LT = 3'b011;
  localparam logic [2:0] MAX = 3'b100, MIN = 3'b101, TRK = 3'b110, CNT = 3'b111;

  logic clk = 1'b0;
  logic rst = 1'b1;

  cmp_unit_pipe_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();

  cmp_unit_pipe #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk (clk),
    .RST (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int              due;
    logic [DW-1:0]   out;
    logic            flag;
    logic [DW-1:0]   tmin;
    logic [DW-1:0]   tmax;
    logic            tvld;
    logic [CW-1:0]   cnt;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   edge_n = 0;
  int   n_vec  = 0;
  int   n_err  = 0;

  // reference model state
  logic [DW-1:0] m_min = '0, m_max = '0;
  logic          m_vld = 1'b0;
  logic [CW-1:0] m_cnt = '0;
  logic          p_vld = 1'b0;
  logic [2:0]    p_fun = NOP;
  logic [DW-1:0] p_a = '0, p_b = '0;
  logic          p_sgn = 1'b0;

  function automatic logic m_lt(input logic [DW-1:0] x, input logic [DW-1:0] y, input logic s);
    return s ? ($signed(x) < $signed(y)) : (x < y);
  endfunction

  // One cycle of stimulus. The edge after this negedge completes the op
  // driven on the previous call, after applying this call's clear.
  task automatic drive(input logic en, input logic [2:0] fun, input logic [DW-1:0] a,
                       input logic [DW-1:0] b, input logic sgn, input logic clr);
    exp_t e;
    @(negedge clk);
    bus.CMP_EN      = en;
    bus.ALU_FUN     = fun;
    bus.A_Cmp       = a;
    bus.B_Cmp       = b;
    bus.SIGNED_MODE = sgn;
    bus.CLR_TRACK   = clr;
`ifdef CMP_TRACK_EN
    if (clr) begin
      m_min = '0; m_max = '0; m_vld = 1'b0; m_cnt = '0;
    end
`endif
    e.due  = edge_n + 1;
    e.flag = p_vld;
    e.out  = '0;
    if (p_vld) begin
      case (p_fun)
        EQ:  e.out = (p_a == p_b) ? 8'd1 : 8'd0;
        GT:  e.out = m_lt(p_b, p_a, p_sgn) ? 8'd2 : 8'd0;
        LT:  e.out = m_lt(p_a, p_b, p_sgn) ? 8'd3 : 8'd0;
        MAX: e.out = m_lt(p_b, p_a, p_sgn) ? p_a : p_b;
        MIN: e.out = m_lt(p_a, p_b, p_sgn) ? p_a : p_b;
`ifdef CMP_TRACK_EN
        TRK: begin
          e.out = p_a;
          if (!m_vld) begin
            m_min = p_a; m_max = p_a; m_vld = 1'b1;
          end else begin
            if (m_lt(p_a, m_min, p_sgn)) m_min = p_a;
            if (m_lt(m_max, p_a, p_sgn)) m_max = p_a;
          end
        end
        CNT: begin
          if (p_a == p_b && m_cnt != 2'b11) m_cnt = m_cnt + 2'd1;
          e.out = {6'b0, m_cnt};
        end
`endif
        default: e.out = '0;
      endcase
    end
    e.tmin = m_min; e.tmax = m_max; e.tvld = m_vld; e.cnt = m_cnt;
    q.push_back(e);
    p_vld = en; p_fun = fun; p_a = a; p_b = b; p_sgn = sgn;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, NOP, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic model_reset();
    q.delete();
    p_vld = 1'b0;
    m_min = '0; m_max = '0; m_vld = 1'b0; m_cnt = '0;
  endtask

  // Scoreboard: each edge either completes a queued expectation or must be idle.
  always begin
    @(posedge clk);
    edge_n++;
    #1;
    if (q.size() != 0 && q[0].due == edge_n) begin
      mon_e = q.pop_front();
      n_vec++;
      if (bus.CMP_Flag_reg !== mon_e.flag) begin
        n_err++; $display("FAIL flag edge %0d: got %0b want %0b", edge_n, bus.CMP_Flag_reg, mon_e.flag);
      end
      if (bus.CMP_OUT_reg !== mon_e.out) begin
        n_err++; $display("FAIL out edge %0d: got %h want %h", edge_n, bus.CMP_OUT_reg, mon_e.out);
      end
      if (bus.TRK_MIN !== mon_e.tmin || bus.TRK_MAX !== mon_e.tmax || bus.TRK_VLD !== mon_e.tvld) begin
        n_err++;
        $display("FAIL tracker edge %0d: got min %h max %h vld %0b want min %h max %h vld %0b",
                 edge_n, bus.TRK_MIN, bus.TRK_MAX, bus.TRK_VLD, mon_e.tmin, mon_e.tmax, mon_e.tvld);
      end
      if (bus.MATCH_CNT !== mon_e.cnt) begin
        n_err++; $display("FAIL match_cnt edge %0d: got %0d want %0d", edge_n, bus.MATCH_CNT, mon_e.cnt);
      end
    end else begin
      n_vec++;
      if (bus.CMP_Flag_reg !== 1'b0 || bus.CMP_OUT_reg !== '0) begin
        n_err++;
        $display("FAIL idle edge %0d: got flag %0b out %h want 0 0", edge_n, bus.CMP_Flag_reg, bus.CMP_OUT_reg);
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    model_reset();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bus.CMP_EN      = 1'($urandom);
      bus.ALU_FUN     = 3'($urandom);
      bus.A_Cmp       = 8'($urandom);
      bus.B_Cmp       = 8'($urandom);
      bus.SIGNED_MODE = 1'($urandom);
      bus.CLR_TRACK   = 1'($urandom);
      n_vec++;
      if (bus.CMP_OUT_reg !== '0 || bus.CMP_Flag_reg !== 1'b0 || bus.TRK_MIN !== '0 ||
          bus.TRK_MAX !== '0 || bus.TRK_VLD !== 1'b0 || bus.MATCH_CNT !== '0) begin
        n_err++;
        $display("FAIL reset_hold: got out %h flag %0b min %h max %h vld %0b cnt %0d want all 0",
                 bus.CMP_OUT_reg, bus.CMP_Flag_reg, bus.TRK_MIN, bus.TRK_MAX, bus.TRK_VLD, bus.MATCH_CNT);
      end
    end
    @(negedge clk);
    bus.CMP_EN = 1'b0; bus.CLR_TRACK = 1'b0;
    rst = 1'b0;
    drive(1'b1, EQ, 8'd5, 8'd5, 1'b0, 1'b0);
    idle(1);
    // Issue edge E+1, result after E+2: at this negedge one edge has passed.
    n_vec++;
    if (bus.CMP_Flag_reg !== 1'b0) begin
      n_err++; $display("FAIL reset_eq_early: got flag %0b want 0", bus.CMP_Flag_reg);
    end
    idle(1);
    n_vec++;
    if (bus.CMP_Flag_reg !== 1'b1 || bus.CMP_OUT_reg !== 8'd1) begin
      n_err++; $display("FAIL reset_eq: got flag %0b out %h want 1 01", bus.CMP_Flag_reg, bus.CMP_OUT_reg);
    end
    idle(1);
  endtask

  task automatic test_signed();
    drive(1'b1, GT,  8'hF0, 8'h10, 1'b0, 1'b0);
    drive(1'b1, GT,  8'hF0, 8'h10, 1'b1, 1'b0);
    drive(1'b1, LT,  8'hF0, 8'h10, 1'b1, 1'b0);
    drive(1'b1, MAX, 8'hF0, 8'h10, 1'b1, 1'b0);
    drive(1'b1, MIN, 8'hF0, 8'h10, 1'b0, 1'b0);
    idle(1);
    n_vec++;
    if (bus.CMP_OUT_reg !== 8'h10) begin
      n_err++; $display("FAIL min_unsigned: got %h want 10", bus.CMP_OUT_reg);
    end
    idle(1);
  endtask

  task automatic test_back_to_back();
    drive(1'b1, EQ,  8'd7, 8'd7, 1'b0, 1'b0);
    drive(1'b1, GT,  8'd9, 8'd2, 1'b0, 1'b0);
    drive(1'b1, LT,  8'd9, 8'd2, 1'b0, 1'b0);
    drive(1'b1, MAX, 8'd9, 8'd2, 1'b0, 1'b0);
    idle(1);
    drive(1'b1, MIN, 8'h80, 8'h7F, 1'b1, 1'b0);
    drive(1'b1, NOP, 8'd1, 8'd1, 1'b0, 1'b0);
    idle(2);
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++)
      drive(1'($urandom), 3'($urandom_range(0, 5)), 8'($urandom_range(0, 3) == 0 ? 8'h33 : $urandom),
            8'h33, 1'($urandom), 1'b0);
    idle(2);
  endtask

  task automatic test_reset_flush();
    drive(1'b1, GT, 8'd8, 8'd1, 1'b0, 1'b0);
    drive(1'b1, EQ, 8'd4, 8'd4, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    n_vec++;
    if (bus.CMP_Flag_reg !== 1'b0 || bus.CMP_OUT_reg !== '0 || bus.TRK_VLD !== 1'b0 || bus.MATCH_CNT !== '0) begin
      n_err++;
      $display("FAIL async_reset: got flag %0b out %h vld %0b cnt %0d want 0", bus.CMP_Flag_reg,
               bus.CMP_OUT_reg, bus.TRK_VLD, bus.MATCH_CNT);
    end
    @(negedge clk);
    bus.CMP_EN = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    idle(3);
  endtask

`ifdef CMP_TRACK_EN
  task automatic test_tracker();
    drive(1'b0, NOP, '0, '0, 1'b0, 1'b1);
    drive(1'b1, TRK, 8'd7, 8'd0, 1'b0, 1'b0);
    drive(1'b1, TRK, 8'd3, 8'd0, 1'b0, 1'b0);
    drive(1'b1, TRK, 8'd9, 8'd0, 1'b0, 1'b0);
    idle(2);
    n_vec++;
    if (bus.TRK_MIN !== 8'd3 || bus.TRK_MAX !== 8'd9 || bus.TRK_VLD !== 1'b1) begin
      n_err++; $display("FAIL track_379: got min %h max %h vld %0b want 03 09 1", bus.TRK_MIN, bus.TRK_MAX, bus.TRK_VLD);
    end
    drive(1'b1, TRK, 8'd4, 8'd0, 1'b0, 1'b0);
    drive(1'b0, NOP, '0, '0, 1'b0, 1'b1);
    idle(1);
    n_vec++;
    if (bus.TRK_MIN !== 8'd4 || bus.TRK_MAX !== 8'd4 || bus.TRK_VLD !== 1'b1) begin
      n_err++; $display("FAIL track_clr_coincident: got min %h max %h vld %0b want 04 04 1", bus.TRK_MIN, bus.TRK_MAX, bus.TRK_VLD);
    end
    drive(1'b0, NOP, '0, '0, 1'b0, 1'b1);
    drive(1'b1, TRK, 8'hF0, 8'd0, 1'b1, 1'b0);
    drive(1'b1, TRK, 8'h05, 8'd0, 1'b1, 1'b0);
    drive(1'b1, TRK, 8'h80, 8'd0, 1'b1, 1'b0);
    idle(2);
  endtask

  task automatic test_counter();
    drive(1'b0, NOP, '0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) drive(1'b1, CNT, 8'd5, 8'd5, 1'b0, 1'b0);
    drive(1'b1, CNT, 8'd1, 8'd2, 1'b0, 1'b0);
    idle(2);
    n_vec++;
    if (bus.MATCH_CNT !== 2'd3) begin
      n_err++; $display("FAIL cnt_saturate: got %0d want 3", bus.MATCH_CNT);
    end
    drive(1'b0, NOP, '0, '0, 1'b0, 1'b1);
    drive(1'b1, CNT, 8'd6, 8'd6, 1'b0, 1'b0);
    drive(1'b1, CNT, 8'd6, 8'd7, 1'b0, 1'b0);
    drive(1'b0, NOP, '0, '0, 1'b0, 1'b1);
    idle(1);
    n_vec++;
    if (bus.MATCH_CNT !== 2'd0) begin
      n_err++; $display("FAIL cnt_clear: got %0d want 0", bus.MATCH_CNT);
    end
    drive(1'b1, CNT, 8'd2, 8'd2, 1'b0, 1'b0);
    drive(1'b0, NOP, '0, '0, 1'b0, 1'b1);
    idle(2);
  endtask
`else
  task automatic test_no_track();
    drive(1'b1, TRK, 8'd9, 8'd0, 1'b0, 1'b0);
    drive(1'b1, CNT, 8'd5, 8'd5, 1'b0, 1'b0);
    idle(1);
    n_vec++;
    if (bus.CMP_Flag_reg !== 1'b1 || bus.CMP_OUT_reg !== 8'd0) begin
      n_err++; $display("FAIL notrack_op: got flag %0b out %h want 1 00", bus.CMP_Flag_reg, bus.CMP_OUT_reg);
    end
    idle(2);
    n_vec++;
    if (bus.TRK_MIN !== '0 || bus.TRK_MAX !== '0 || bus.TRK_VLD !== 1'b0 || bus.MATCH_CNT !== '0) begin
      n_err++;
      $display("FAIL notrack_tied: got min %h max %h vld %0b cnt %0d want 0", bus.TRK_MIN, bus.TRK_MAX,
               bus.TRK_VLD, bus.MATCH_CNT);
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bus.CMP_EN = 1'b0; bus.ALU_FUN = NOP; bus.A_Cmp = '0; bus.B_Cmp = '0;
    bus.SIGNED_MODE = 1'b0; bus.CLR_TRACK = 1'b0;
    test_reset();
    test_signed();
    test_back_to_back();
    test_random();
    test_reset_flush();
`ifdef CMP_TRACK_EN
    test_tracker();
    test_counter();
`else
    test_no_track();
`endif
    idle(2);
    for (int i = 0; i < 10 && q.size() > 1; i++) @(negedge clk);
    // The last idle push is due one edge after this point.
    @(negedge clk);
    n_vec++;
    if (q.size() != 0) begin
      n_err++; $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
